// File: rtl/mem_read_arbiter_pkg.sv
// ============================================================================
// mem_read_arbiter_pkg : shared types for the fetch/load memory read arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_read_arbiter_pkg;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LOAD  = 1'b1
  } req_id_e;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_NORMAL = 1'b0;
  localparam arb_state_t ST_BOOST  = 1'b1;

  localparam int WAIT_W = 4;

  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    killed;
  } inflight_t;

  // Marks a fetch entry as killed when a flush is active; loads pass through.
  function automatic inflight_t kill_fetch_entry(input inflight_t e, input logic kill);
    inflight_t r;
    r = e;
    if (kill && e.id == REQ_FETCH) r.killed = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_read_arbiter_inflight_pipe.sv
// ============================================================================
// inflight_pipe : DEPTH-deep shift register of in-flight read entries with
//                 kill-by-id (fetch) on flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module inflight_pipe
  import mem_read_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  inflight_t push,
  input  logic      kill_fetch,
  output inflight_t head
);

  inflight_t r_stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      // A fetch is never granted in a flush cycle, so the new entry needs no kill.
      r_stage[0] <= push;
      for (int i = 1; i < DEPTH; i++)
        r_stage[i] <= kill_fetch_entry(r_stage[i-1], kill_fetch);
    end
  end

  // The entry responding in a flush cycle is still in flight, so it is killed too.
  assign head = kill_fetch_entry(r_stage[DEPTH-1], kill_fetch);

endmodule

`default_nettype wire

// File: rtl/mem_read_arbiter.sv
// ============================================================================
// mem_read_arbiter : two-requester (fetch/load) arbiter for a fixed-latency
//                    memory read port with anti-starvation fetch boost.
// Optional: MEM_READ_ARBITER_STATS_EN adds grant/boost statistic counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int LATENCY  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [15:1] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic [15:1] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  input  logic        flush,
  output logic [15:1] mem_raddr,
  input  logic [15:0] mem_rdata
`ifdef MEM_READ_ARBITER_STATS_EN
  ,
  output logic [15:0] stat_f_grants,
  output logic [15:0] stat_d_grants,
  output logic [15:0] stat_boosts
`endif
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

  arb_state_t        r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic [15:1]       r_last_addr;
  logic              w_f_ok;
  logic              w_boost_entry;
  inflight_t         w_push, w_head;

  assign w_f_ok = f_req & ~flush;

  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (r_state == ST_BOOST) begin
        if (w_f_ok)     f_gnt = 1'b1;
        else if (d_req) d_gnt = 1'b1;
      end else begin
        if (d_req)       d_gnt = 1'b1;
        else if (w_f_ok) f_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_raddr = r_last_addr;
    if (f_gnt)      mem_raddr = f_addr;
    else if (d_gnt) mem_raddr = d_addr;
  end

  // Flush cycles neither count as denials nor clear the streak.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!f_req || f_gnt)          w_wait_nxt = '0;
    else if (flush)               w_wait_nxt = r_wait_cnt;
    else if (r_wait_cnt != WAIT_SAT) w_wait_nxt = r_wait_cnt + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_NORMAL) begin
      if (w_wait_nxt >= MAX_WAIT_W) w_state_nxt = ST_BOOST;
    end else begin
      if (f_gnt || !f_req) w_state_nxt = ST_NORMAL;
    end
  end

  assign w_boost_entry = (r_state == ST_NORMAL) && (w_state_nxt == ST_BOOST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_NORMAL;
      r_wait_cnt  <= '0;
      r_last_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_last_addr <= mem_raddr;
    end
  end

  always_comb begin
    w_push        = '0;
    w_push.valid  = f_gnt | d_gnt;
    w_push.id     = d_gnt ? REQ_LOAD : REQ_FETCH;
    w_push.killed = 1'b0;
  end

  inflight_pipe #(
    .DEPTH (LATENCY)
  ) u_pipe (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .kill_fetch (flush),
    .head       (w_head)
  );

  assign f_rvalid = w_head.valid && (w_head.id == REQ_FETCH) && !w_head.killed;
  assign d_rvalid = w_head.valid && (w_head.id == REQ_LOAD);
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

`ifdef MEM_READ_ARBITER_STATS_EN
  logic [15:0] r_stat_f, r_stat_d, r_stat_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_f <= '0;
      r_stat_d <= '0;
      r_stat_b <= '0;
    end else begin
      if (f_gnt)         r_stat_f <= r_stat_f + 16'd1;
      if (d_gnt)         r_stat_d <= r_stat_d + 16'd1;
      if (w_boost_entry) r_stat_b <= r_stat_b + 16'd1;
    end
  end

  assign stat_f_grants = r_stat_f;
  assign stat_d_grants = r_stat_d;
  assign stat_boosts   = r_stat_b;
`else
  logic w_unused;
  assign w_unused = w_boost_entry;
`endif

endmodule

`default_nettype wire

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2: fixed memory read latency in cycles, from address presented to rdata valid; legal 1..4.
REQ-002 SHALL have parameter MAX_WAIT, default 4: consecutive denied fetch-request cycles before fetch boost; legal 1..15.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Ports f_req / f_addr, input, 1 / [15:1]: fetch read request and word address.
REQ-006 Port f_gnt, output, 1: fetch request accepted this cycle.
REQ-007 Ports f_rvalid / f_rdata, output, 1 / 16: fetch response strobe and data.
REQ-008 Ports d_req / d_addr, input, 1 / [15:1]: load read request and word address.
REQ-009 Port d_gnt, output, 1: load request accepted this cycle.
REQ-010 Ports d_rvalid / d_rdata, output, 1 / 16: load response strobe and data.
REQ-011 Port flush, input, 1: pipeline redirect; kills fetch traffic.
REQ-012 Ports mem_raddr / mem_rdata, output [15:1] / input 16: shared memory read port.

Function
REQ-013 Grant SHALL be combinational in the request cycle; at most one of f_gnt, d_gnt high per cycle.
REQ-014 Requester SHALL hold req and addr stable until granted; the arbiter does not latch ungranted requests.
REQ-015 mem_raddr SHALL equal the granted address; with no grant, it holds its last value.
REQ-016 FSM states: NORMAL and BOOST.
REQ-017 NORMAL: d_req wins over f_req.
REQ-018 BOOST: f_req wins over d_req.
REQ-019 wait_cnt (4 bit, saturating): increments when f_req=1 and f_gnt=0 (excluding flush cycles); clears on f_gnt or f_req=0.
REQ-020 NORMAL->BOOST when wait_cnt reaches MAX_WAIT; BOOST->NORMAL after the cycle in which f_gnt=1, or when f_req drops.
REQ-021 Each grant SHALL push {valid, id} into a LATENCY-deep in-flight pipe.
REQ-022 Response fires exactly LATENCY cycles after grant, on the matching rvalid; rdata = mem_rdata in that cycle.
REQ-023 Back-to-back grants SHALL yield back-to-back responses in grant order; throughput 1/cycle.
REQ-024 flush=1 forces f_gnt=0 that cycle and marks all in-flight fetch entries killed; killed entries produce no f_rvalid.
REQ-025 flush SHALL NOT affect d_gnt or in-flight load entries.
REQ-026 f_rdata/d_rdata are don't-care when the corresponding rvalid=0, but SHALL carry no X when rvalid=1.

Reset
REQ-027 On reset: FSM=NORMAL, wait_cnt=0, in-flight pipe cleared, mem_raddr=0, all rvalid=0, gnt driven by requests only after reset deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight requests; no response for them ever appears.

Configuration
REQ-029 Macro MEM_READ_ARBITER_STATS_EN defined: outputs stat_f_grants[15:0], stat_d_grants[15:0], stat_boosts[15:0] (wrapping counters, reset to 0, incremented on f_gnt, d_gnt, and NORMAL->BOOST entry).
REQ-030 Macro undefined: these ports and counters SHALL be absent; behaviour is otherwise identical.

Structure
REQ-031 A shared package SHALL hold requester-id enum (REQ_FETCH=0, REQ_LOAD=1), FSM state typedef, and in-flight entry struct {valid, id, killed}.
REQ-032 Sub-module inflight_pipe (LATENCY-deep shift register of entries with kill-by-id input) SHALL be used.

Verification
REQ-033 With only f_req=1 and f_addr=0x0010 for 1 cycle: f_gnt=1, mem_raddr=0x0010, f_rvalid=1 exactly 2 cycles later.
REQ-034 With f_req and d_req held continuously: d_gnt for 4 cycles, then f_gnt once (BOOST), then d_gnt resumes; pattern repeats with period 5.
REQ-035 Fetch granted at cycle 0, flush at cycle 1: no f_rvalid at cycle 2; a load granted at cycle 1 still yields d_rvalid at cycle 3.
REQ-036 Alternating f/d grants for 6 cycles: responses arrive in grant order, one per cycle, ids matching.
REQ-037 Reset asserted 1 cycle after a d_gnt: d_rvalid never asserts; all outputs 0 during reset.
REQ-038 With MEM_READ_ARBITER_STATS_EN and 3 fetch + 2 load grants: stat_f_grants=3, stat_d_grants=2.
